// File: rtl/tick_interval_meter.sv
// rtl/tick_interval_meter.sv - period and high-time meter for a synchronised tick line
module tick_interval_meter #(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT     = 1000000,
    parameter int SYNC_STAGES = 2,
    parameter bit IDLE        = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_n_reset,
    input  logic             i_enable,
    input  logic             i_tick,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high,
    output logic             o_overrun,
    output logic             o_timeout
);

    // The timeout counter only ever has to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic [WIDTH-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_high;
    logic                   high_open;
    logic                   high_seen;
    logic [TW-1:0]          t_cnt;
    logic [TW-1:0]          t_inc;
    logic [WIDTH-1:0]       cnt_inc;
    logic                   tmo_hit;
    logic                   res_fire;
    logic [WIDTH-1:0]       res_period;
    logic [WIDTH-1:0]       res_high;

    // Input synchroniser chain; the oldest stage feeds edge detection.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_tick};
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ IDLE;

    // One-cycle delayed copy of the normalised level for edge detection.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Saturating increments, timeout detection and the result being completed this cycle.
    always_comb begin
        cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + WIDTH'(1);
        t_inc      = (TIMEOUT == 0) ? '0 : t_cnt + TW'(1);
        tmo_hit    = (TIMEOUT != 0) && (state != ST_OFF) && !rise && (t_cnt == T_LAST);
        res_fire   = i_enable && (state == ST_MEAS) && rise;
        res_period = cnt_inc;
        res_high   = high_seen ? r_high : cnt_inc;
    end

    // Measurement FSM: arms on the first rise, then measures rise-to-rise intervals.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state     <= ST_OFF;
            r_cnt     <= '0;
            r_high    <= '0;
            high_open <= 1'b0;
            high_seen <= 1'b0;
            t_cnt     <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            if (!i_enable) begin
                state     <= ST_OFF;
                r_cnt     <= '0;
                r_high    <= '0;
                high_open <= 1'b0;
                high_seen <= 1'b0;
                t_cnt     <= '0;
            end else begin
                case (state)
                    ST_OFF: begin
                        state <= ST_ARM;
                        t_cnt <= '0;
                    end
                    ST_ARM: begin
                        if (rise) begin
                            state     <= ST_MEAS;
                            r_cnt     <= '0;
                            r_high    <= '0;
                            high_open <= 1'b1;
                            high_seen <= 1'b0;
                            t_cnt     <= '0;
                        end else if (tmo_hit) begin
                            o_timeout <= 1'b1;
                            t_cnt     <= '0;
                        end else begin
                            t_cnt <= t_inc;
                        end
                    end
                    ST_MEAS: begin
                        if (rise) begin
                            // Result for the interval just closed leaves via res_fire.
                            r_cnt     <= '0;
                            r_high    <= '0;
                            high_open <= 1'b1;
                            high_seen <= 1'b0;
                            t_cnt     <= '0;
                        end else if (tmo_hit) begin
                            state     <= ST_ARM;
                            o_timeout <= 1'b1;
                            r_cnt     <= '0;
                            r_high    <= '0;
                            high_open <= 1'b0;
                            high_seen <= 1'b0;
                            t_cnt     <= '0;
                        end else begin
                            r_cnt <= cnt_inc;
                            t_cnt <= t_inc;
                            if (fall && high_open) begin
                                r_high    <= cnt_inc;
                                high_open <= 1'b0;
                                high_seen <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_OFF;
                    end
                endcase
            end
        end
    end

    // Result register with valid/ready handshake; a result arriving while one is held is dropped.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            o_valid   <= 1'b0;
            o_period  <= '0;
            o_high    <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (res_fire && (!o_valid || i_ready)) begin
                o_valid  <= 1'b1;
                o_period <= res_period;
                o_high   <= res_high;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            if (o_valid && i_ready) begin
                o_overrun <= 1'b0;
            end else if (res_fire && o_valid) begin
                o_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tick_interval_meter.sv
// tb/tb_tick_interval_meter.sv - randomized bench with timestamp-based reference model
module tb_tick_interval_meter;

    localparam int NI = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic tick  = 1'b0;
    logic rdy   = 1'b0;
    logic tick_n;

    logic       va, vb, vc;
    logic [7:0] pa, ha, pb, hb;
    logic [3:0] pc, hc;
    logic       ova, ovb, ovc;
    logic       toa, tob, toc;

    assign tick_n = ~tick;

    always #5 clk = ~clk;

    tick_interval_meter #(.WIDTH(8), .TIMEOUT(20), .SYNC_STAGES(2), .IDLE(1'b0)) dut_a (
        .i_clk(clk), .i_n_reset(rst_n), .i_enable(en), .i_tick(tick), .i_ready(rdy),
        .o_valid(va), .o_period(pa), .o_high(ha), .o_overrun(ova), .o_timeout(toa));

    tick_interval_meter #(.WIDTH(8), .TIMEOUT(20), .SYNC_STAGES(2), .IDLE(1'b1)) dut_b (
        .i_clk(clk), .i_n_reset(rst_n), .i_enable(en), .i_tick(tick_n), .i_ready(rdy),
        .o_valid(vb), .o_period(pb), .o_high(hb), .o_overrun(ovb), .o_timeout(tob));

    tick_interval_meter #(.WIDTH(4), .TIMEOUT(40), .SYNC_STAGES(2), .IDLE(1'b0)) dut_c (
        .i_clk(clk), .i_n_reset(rst_n), .i_enable(en), .i_tick(tick), .i_ready(rdy),
        .o_valid(vc), .o_period(pc), .o_high(hc), .o_overrun(ovc), .o_timeout(toc));

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int tout(input int i);
        return (i == 2) ? 40 : 20;
    endfunction

    function automatic int pmax(input int i);
        return (i == 2) ? 15 : 255;
    endfunction

    function automatic bit idle_lvl(input int i);
        return (i == 1);
    endfunction

    function automatic int sat(input int i, input int x);
        return (x > pmax(i)) ? pmax(i) : x;
    endfunction

    // Reference model: timestamps of edges and arm points, outputs derived by arithmetic.
    int  cyc = 0;
    int  m_mode [NI];
    int  m_ref  [NI];
    int  m_rise [NI];
    int  m_fall [NI];
    bit  m_hist [NI][3];
    bit  e_v    [NI];
    int  e_p    [NI];
    int  e_h    [NI];
    bit  e_o    [NI];
    bit  e_t    [NI];
    bit  t_snow, t_sold, t_rise, t_fall, t_fire, t_tmo, t_acc;
    int  t_per, t_hi;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_mode[i] = 0; m_ref[i] = 0; m_rise[i] = 0; m_fall[i] = -1;
                m_hist[i][0] = 0; m_hist[i][1] = 0; m_hist[i][2] = 0;
                e_v[i] = 0; e_p[i] = 0; e_h[i] = 0; e_o[i] = 0; e_t[i] = 0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < NI; i++) begin
                t_snow = m_hist[i][1] ^ idle_lvl(i);
                t_sold = m_hist[i][2] ^ idle_lvl(i);
                t_rise = t_snow & ~t_sold;
                t_fall = ~t_snow & t_sold;
                m_hist[i][2] = m_hist[i][1];
                m_hist[i][1] = m_hist[i][0];
                m_hist[i][0] = (i == 1) ? tick_n : tick;
                t_fire = 0; t_tmo = 0; t_per = 0; t_hi = 0;
                if (!en) begin
                    m_mode[i] = 0;
                end else if (m_mode[i] == 0) begin
                    m_mode[i] = 1; m_ref[i] = cyc;
                end else if (t_rise) begin
                    if (m_mode[i] == 2) begin
                        t_fire = 1;
                        t_per  = sat(i, cyc - m_rise[i]);
                        t_hi   = (m_fall[i] < 0) ? t_per : sat(i, m_fall[i] - m_rise[i]);
                    end
                    m_mode[i] = 2; m_rise[i] = cyc; m_fall[i] = -1; m_ref[i] = cyc;
                end else if (cyc - m_ref[i] == tout(i)) begin
                    t_tmo = 1; m_mode[i] = 1; m_ref[i] = cyc;
                end else if (m_mode[i] == 2 && t_fall && m_fall[i] < 0) begin
                    m_fall[i] = cyc;
                end
                t_acc = e_v[i] & rdy;
                if (t_fire) begin
                    if (!e_v[i] || rdy) begin
                        e_v[i] = 1; e_p[i] = t_per; e_h[i] = t_hi;
                    end else begin
                        e_o[i] = 1;
                    end
                end else if (t_acc) begin
                    e_v[i] = 0;
                end
                if (t_acc) e_o[i] = 0;
                e_t[i] = t_tmo;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_inst(input int i, input logic v, input logic [31:0] p, input logic [31:0] h,
                            input logic ov, input logic to);
        chk($sformatf("valid[%0d]", i),   {31'd0, v},  {31'd0, e_v[i]});
        chk($sformatf("period[%0d]", i),  p,           32'(e_p[i]));
        chk($sformatf("high[%0d]", i),    h,           32'(e_h[i]));
        chk($sformatf("overrun[%0d]", i), {31'd0, ov}, {31'd0, e_o[i]});
        chk($sformatf("timeout[%0d]", i), {31'd0, to}, {31'd0, e_t[i]});
    endtask

    int last_pa = 0, last_ha = 0, last_pb = 0, last_hb = 0, last_pc = 0, last_hc = 0;
    int n_val_a = 0, n_tmo_a = 0;

    // Every-cycle comparison against the model, plus captures for literal checks.
    always @(posedge clk) begin
        #1;
        chk_inst(0, va, 32'(pa), 32'(ha), ova, toa);
        chk_inst(1, vb, 32'(pb), 32'(hb), ovb, tob);
        chk_inst(2, vc, 32'(pc), 32'(hc), ovc, toc);
        if (va) begin last_pa = pa; last_ha = ha; n_val_a++; end
        if (vb) begin last_pb = pb; last_hb = hb; end
        if (vc) begin last_pc = pc; last_hc = hc; end
        if (toa) n_tmo_a++;
    end

    bit rdy_rand = 0;

    task automatic drive(input logic t);
        @(negedge clk);
        tick = t;
        if (rdy_rand) rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < hi; k++) drive(1'b1);
            for (int k = 0; k < lo; k++) drive(1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0);
    endtask

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    int hi_r, lo_r, reps_r;

    initial begin
        // Reset held with the tick toggling: everything must stay cleared.
        rst_n = 0; en = 0; rdy = 1;
        for (int k = 0; k < 6; k++) drive(k[0]);
        chk("reset_valid", {31'd0, va}, 32'd0);
        chk("reset_period", 32'(pa), 32'd0);
        chk("reset_timeout", {31'd0, toa}, 32'd0);
        @(negedge clk); rst_n = 1;
        idle(4);
        en = 1;

        // 4 high / 4 low.
        wave(4, 4, 6);
        chk("div8_period", 32'(last_pa), 32'd8);
        chk("div8_high", 32'(last_ha), 32'd4);

        // 1-cycle pulse every 5 cycles, normal and inverted-idle instance.
        wave(1, 4, 6);
        chk("pulse5_period", 32'(last_pa), 32'd5);
        chk("pulse5_high", 32'(last_ha), 32'd1);
        chk("pulse5_inv_period", 32'(last_pb), 32'd5);
        chk("pulse5_inv_high", 32'(last_hb), 32'd1);

        // Hold a result unaccepted while two more complete.
        rdy = 0;
        wave(1, 6, 1);
        wave(1, 6, 2);
        idle(6);
        chk("held_valid", {31'd0, va}, 32'd1);
        chk("held_period", 32'(pa), 32'd5);
        chk("held_overrun", {31'd0, ova}, 32'd1);
        rdy = 1;
        @(negedge clk); rdy = 0;
        chk("accept_valid", {31'd0, va}, 32'd0);
        chk("accept_overrun", {31'd0, ova}, 32'd0);
        rdy = 1;

        // Tick stuck low: one timeout pulse, then two rises needed for a result.
        wave(1, 4, 3);
        n_tmo_a = 0;
        idle(30);
        chk("timeout_count", 32'(n_tmo_a), 32'd1);
        n_val_a = 0;
        wave(1, 4, 1);
        idle(2);
        chk("rearm_no_valid", 32'(n_val_a), 32'd0);
        wave(1, 4, 2);
        chk("rearm_valid_count", 32'(n_val_a), 32'd2);

        // Period 20: exactly at the timeout boundary for a/b, saturating for c.
        wave(3, 17, 3);
        chk("p20_period", 32'(last_pa), 32'd20);
        chk("p20_high", 32'(last_ha), 32'd3);
        chk("sat_period", 32'(last_pc), 32'd15);
        chk("sat_high", 32'(last_hc), 32'd3);

        // Enable dropped mid-period.
        wave(2, 6, 2);
        drive(1'b1); drive(1'b1); drive(1'b0); drive(1'b0);
        n_val_a = 0;
        en = 0;
        idle(3);
        en = 1;
        idle(2);
        wave(2, 6, 1);
        idle(2);
        chk("disable_no_valid", 32'(n_val_a), 32'd0);
        wave(2, 6, 2);
        chk("reenable_period", 32'(last_pa), 32'd8);
        chk("reenable_high", 32'(last_ha), 32'd2);

        // Randomized traffic with random ready, enable drops and long idles.
        rdy_rand = 1;
        for (int seg = 0; seg < 40; seg++) begin
            hi_r   = $urandom_range(1, 10);
            lo_r   = $urandom_range(1, 25);
            reps_r = $urandom_range(1, 4);
            if ($urandom_range(0, 7) == 0) begin
                en = 0;
                idle($urandom_range(1, 6));
                en = 1;
            end
            if ($urandom_range(0, 7) == 0) idle(45);
            wave(hi_r, lo_r, reps_r);
        end
        rdy_rand = 0;

        // Asynchronous reset mid-measurement with a held result and overrun.
        rdy = 0;
        wave(2, 3, 4);
        chk("pre_reset_valid", {31'd0, va}, 32'd1);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("async_valid", {31'd0, va}, 32'd0);
        chk("async_period", 32'(pa), 32'd0);
        chk("async_high", 32'(ha), 32'd0);
        chk("async_overrun", {31'd0, ova}, 32'd0);
        en = 0;
        idle(2);
        rst_n = 1;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
